// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding and the
// register map of the peripheral it normally talks to.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  // Completer register addresses
  localparam logic [2:0] CR1 = 3'd0;
  localparam logic [2:0] CR2 = 3'd1;
  localparam logic [2:0] BR  = 3'd2;
  localparam logic [2:0] SR  = 3'd3;
  localparam logic [2:0] DR  = 3'd5;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO. Besides the head entry it also exposes the entry
// that becomes the head after a pop. That lets the bridge load its registered
// APB outputs for a back-to-back transfer on the same edge as the pop. DEPTH
// must be a power of two, at least 2.
module apb_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         next_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next_idx;
  logic             do_push, do_pop;

  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign rd_next_idx = rd_ptr_q[PTR_W-1:0] + 1'b1;
  assign head_data   = mem_q[rd_ptr_q[PTR_W-1:0]];
  // With a single stored entry, the post-pop head is whatever is pushed now.
  assign next_data   = (count > ONE) ? mem_q[rd_next_idx] : push_data;

  // Pointer next-state
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Local command to APB requester bridge. Commands are buffered in a small
// FIFO and executed in order as SETUP/ACCESS transfers with a wait-state
// timeout. All APB outputs are registered and computed from the next state.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic              PClk,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W:0]   ONE_ENTRY = 1;

  // Command FIFO interface
  logic             push, pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] push_data, head_data, next_data, load_data;
  logic [PTR_W:0]   fifo_count;

  // FSM, timeout counter, APB and response registers
  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              load, tmo_hit;

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;
  assign push_data = {req_write, req_addr, req_wdata};

  apb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (PClk),
    .rst_n     (PRESETn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .next_data (next_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next state, timeout counting, completion and registered-output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    load        = 1'b0;
    load_data   = head_data;
    tmo_hit     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        tmo_hit = !PREADY && (cnt_q == TMO_LAST);
        if (PREADY || tmo_hit) begin
          pop         = 1'b1;
          rsp_valid_d = 1'b1;
          // A ready completer wins over an expiring timeout.
          rsp_err_d   = PREADY ? PSLVERR : 1'b1;
          rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
          // A command pushed on this same edge also counts as "still queued".
          if ((fifo_count > ONE_ENTRY) || push) begin
            state_d   = SETUP;
            load      = 1'b1;
            load_data = next_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pwrite_d = load_data[CMD_W-1];
      paddr_d  = load_data[DATA_W +: ADDR_W];
      pwdata_d = load_data[CMD_W-1] ? load_data[DATA_W-1:0] : '0;
    end else if (state_d == IDLE) begin
      pwrite_d = 1'b0;
      paddr_d  = '0;
      pwdata_d = '0;
    end

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // State, counter, APB and response registers
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a queue-based transaction model predicts every
// APB and response output each cycle, a reactive completer inserts wait
// states, and directed scenarios pin latency, wait/timeout lengths and data.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int TMO    = 16;
  localparam int DEPTH  = 2;

  logic              PClk = 1'b0;
  logic              PRESETn;
  logic              req_valid = 1'b0, req_write = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA = '0;
  logic              PREADY = 1'b0, PSLVERR = 1'b0;

  always #5 PClk = ~PClk;

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .PClk(PClk), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct { logic w; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } cmd_t;
  typedef struct { logic [DATA_W-1:0] rdata; logic err; } rsp_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  cmd_t              m_q[$];
  bit                m_active, m_setup;
  int                m_wait;
  bit                e_rsp_valid, e_rsp_err;
  logic [DATA_W-1:0] e_rsp_rdata;

  always @(posedge PClk or negedge PRESETn) begin : model
    bit accept, more;
    if (!PRESETn) begin
      m_q.delete();
      m_active = 0; m_setup = 0; m_wait = 0;
      e_rsp_valid = 0; e_rsp_err = 0; e_rsp_rdata = '0;
    end else begin
      accept = req_valid && (m_q.size() < DEPTH);
      e_rsp_valid = 0; e_rsp_err = 0; e_rsp_rdata = '0;
      if (!m_active) begin
        if (m_q.size() != 0) begin m_active = 1; m_setup = 1; end
      end else if (m_setup) begin
        m_setup = 0; m_wait = 0;
      end else if (PREADY || m_wait == TMO - 1) begin
        e_rsp_valid = 1;
        e_rsp_err   = PREADY ? PSLVERR : 1'b1;
        e_rsp_rdata = (PREADY && !m_q[0].w) ? PRDATA : '0;
        void'(m_q.pop_front());
        more = (m_q.size() != 0) || accept;
        m_active = more; m_setup = more;
      end else begin
        m_wait++;
      end
      if (accept) m_q.push_back('{req_write, req_addr, req_wdata});
    end
  end

  // ---------------- cycle counter and completer ----------------
  int cyc = 0;
  always @(posedge PClk) cyc++;

  int                slave_wait = 0;
  logic [DATA_W-1:0] slave_rdata = '0;
  logic              slave_err = 1'b0;
  int                acc_idx = 0;

  always @(posedge PClk) begin
    #3;
    if (!PRESETn) begin
      acc_idx = 0; PREADY = 1'b0;
    end else if (PSEL && PENABLE) begin
      PREADY = (acc_idx >= slave_wait);
      acc_idx++;
    end else begin
      acc_idx = 0; PREADY = 1'b0;
    end
    PRDATA  = slave_rdata;
    PSLVERR = slave_err;
  end

  // ---------------- per-cycle compare and monitor ----------------
  rsp_t rsp_log[$];
  int   psel_run = 0, pen_run = 0, last_psel_run = 0, last_pen_run = 0;
  int   psel_rise_cyc = 0, pen_rise_cyc = 0, rsp_cyc = 0;

  always @(posedge PClk) begin
    #1;
    if (!PRESETn) begin
      psel_run = 0; pen_run = 0;
    end else begin
      check("psel", PSEL, m_active);
      check("penable", PENABLE, m_active && !m_setup);
      check("pwdata", PWDATA, (m_active && m_q[0].w) ? m_q[0].d : '0);
      if (m_active) begin
        check("paddr", PADDR, m_q[0].a);
        check("pwrite", PWRITE, m_q[0].w);
      end
      check("req_ready", req_ready, m_q.size() < DEPTH);
      check("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid) begin
        check("rsp_rdata", rsp_rdata, e_rsp_rdata);
        check("rsp_err", rsp_err, e_rsp_err);
      end

      if (PSEL) begin
        if (psel_run == 0) psel_rise_cyc = cyc;
        psel_run++;
      end else begin
        if (psel_run > 0) last_psel_run = psel_run;
        psel_run = 0;
      end
      if (PENABLE) begin
        if (pen_run == 0) pen_rise_cyc = cyc;
        pen_run++;
      end else begin
        if (pen_run > 0) last_pen_run = pen_run;
        pen_run = 0;
      end
      if (rsp_valid) begin
        rsp_log.push_back('{rsp_rdata, rsp_err});
        rsp_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+3) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge PClk); #3; end
  endtask

  task automatic push_cmd(input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output int acc_cyc);
    bit got = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 50 && !got; i++) begin
      got = req_ready;
      @(posedge PClk); #3;
    end
    acc_cyc   = cyc;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    if (!got) check("push_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200 && rsp_log.size() < n; i++) begin
      @(posedge PClk); #3;
    end
    if (rsp_log.size() < n) check("wait_rsp_timeout", rsp_log.size(), n);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n0, n1;
    bit seen;
    PRESETn = 1'b1;
    #1 PRESETn = 1'b0;
    #2;
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 1);
    repeat (2) @(posedge PClk);
    #3 PRESETn = 1'b1;
    idle(2);

    // Write 0x5A to DR, completer ready at once: latency N+1/N+2/N+3
    slave_wait = 0;
    push_cmd(1'b1, DR, 8'h5A, n0);
    wait_rsp(1);
    idle(2);
    check("t1_psel_rise", psel_rise_cyc, n0 + 1);
    check("t1_penable_rise", pen_rise_cyc, n0 + 2);
    check("t1_rsp_cycle", rsp_cyc, n0 + 3);
    check("t1_pen_cycles", last_pen_run, 1);
    check("t1_psel_cycles", last_psel_run, 2);
    check("t1_rdata", rsp_log[0].rdata, 8'h00);
    check("t1_err", rsp_log[0].err, 0);

    // Read CR1 with three wait states
    slave_wait = 3; slave_rdata = 8'h04;
    push_cmd(1'b0, CR1, 8'hEE, n0);
    wait_rsp(2);
    idle(2);
    check("t2_pen_cycles", last_pen_run, 4);
    check("t2_rdata", rsp_log[1].rdata, 8'h04);
    check("t2_err", rsp_log[1].err, 0);

    // Back-to-back: write CR2 then read BR; FIFO full after the second push
    slave_wait = 0; slave_rdata = 8'h77;
    push_cmd(1'b1, CR2, 8'hA5, n0);
    push_cmd(1'b0, BR, 8'h00, n1);
    check("t3_ready_when_full", req_ready, 0);
    check("t3_accept_gap", n1 - n0, 1);
    wait_rsp(4);
    idle(2);
    check("t3_psel_cycles", last_psel_run, 4);
    check("t3_rsp0_rdata", rsp_log[2].rdata, 8'h00);
    check("t3_rsp0_err", rsp_log[2].err, 0);
    check("t3_rsp1_rdata", rsp_log[3].rdata, 8'h77);
    check("t3_rsp1_err", rsp_log[3].err, 0);

    // Completer never ready: abort after 16 ACCESS cycles
    slave_wait = 100; slave_rdata = 8'hFF;
    push_cmd(1'b0, SR, 8'h00, n0);
    wait_rsp(5);
    idle(2);
    check("t4_pen_cycles", last_pen_run, 16);
    check("t4_rdata", rsp_log[4].rdata, 8'h00);
    check("t4_err", rsp_log[4].err, 1);

    // Ready on the 16th ACCESS cycle: normal completion wins
    slave_wait = 15; slave_rdata = 8'h3C;
    push_cmd(1'b0, SR, 8'h00, n0);
    wait_rsp(6);
    idle(2);
    check("t5_pen_cycles", last_pen_run, 16);
    check("t5_rdata", rsp_log[5].rdata, 8'h3C);
    check("t5_err", rsp_log[5].err, 0);

    // PSLVERR at completion
    slave_wait = 0; slave_rdata = 8'h11; slave_err = 1'b1;
    push_cmd(1'b0, DR, 8'h00, n0);
    wait_rsp(7);
    idle(2);
    check("t6_rdata", rsp_log[6].rdata, 8'h11);
    check("t6_err", rsp_log[6].err, 1);
    slave_err = 1'b0;

    // Reset in the middle of ACCESS
    slave_wait = 100;
    push_cmd(1'b1, CR1, 8'h99, n0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      seen = PENABLE;
      if (!seen) idle(1);
    end
    if (!seen) check("t7_access_timeout", 32'd0, 32'd1);
    idle(2);
    PRESETn = 1'b0;
    #1;
    check("t7_psel_async", PSEL, 0);
    check("t7_penable_async", PENABLE, 0);
    check("t7_pwdata_async", PWDATA, 0);
    check("t7_req_ready", req_ready, 1);
    check("t7_rsp_valid", rsp_valid, 0);
    @(posedge PClk); @(posedge PClk);
    #3 PRESETn = 1'b1;
    slave_wait = 0;
    idle(4);
    check("t7_no_rsp", rsp_log.size(), 7);
    check("t7_stays_idle", PSEL, 0);
    push_cmd(1'b1, SR, 8'h42, n0);
    wait_rsp(8);
    idle(2);
    check("t7_after_rdata", rsp_log[7].rdata, 8'h00);
    check("t7_after_err", rsp_log[7].err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter ADDR_W, default 3, APB address width.
REQ-002 Parameter DATA_W, default 8, APB data width.
REQ-003 Parameter TIMEOUT_CYC, default 16, maximum ACCESS cycles before abort (minimum 2).
REQ-004 Parameter FIFO_DEPTH, default 2, command buffer entries (power of 2).
REQ-005 Port PClk, input, 1, single clock; all logic rising-edge.
REQ-006 Port PRESETn, input, 1, reset, asynchronous assert, active-low.
REQ-007 Port req_valid, input, 1, local command offered.
REQ-008 Port req_ready, output, 1, command accepted when req_valid && req_ready.
REQ-009 Port req_write, input, 1, 1 = write, 0 = read.
REQ-010 Port req_addr, input, ADDR_W, target register address.
REQ-011 Port req_wdata, input, DATA_W, write data.
REQ-012 Port rsp_valid, output, 1, one-cycle completion pulse; no backpressure.
REQ-013 Port rsp_rdata, output, DATA_W, read data; 0 for writes and timeouts.
REQ-014 Port rsp_err, output, 1, PSLVERR sampled at completion, or 1 on timeout.
REQ-015 Ports PSEL, PENABLE, PWRITE (outputs, 1), PADDR (output, ADDR_W), PWDATA (output, DATA_W): APB requester signals, all registered.
REQ-016 Ports PRDATA (input, DATA_W), PREADY (input, 1), PSLVERR (input, 1): APB completer returns.

Function
REQ-017 req_ready SHALL equal !fifo_full; accepted commands SHALL be queued in order.
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-019 IDLE: PSEL=0, PENABLE=0; if FIFO non-empty, the next state SHALL be SETUP.
REQ-020 SETUP SHALL last exactly one cycle: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the FIFO head; the next state is ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA SHALL stay stable until completion.
REQ-022 Completion SHALL occur on the edge where PREADY=1 in ACCESS: pop the FIFO head, capture PRDATA (reads only) and PSLVERR, and assert rsp_valid for the following cycle.
REQ-023 After completion the FSM SHALL go to SETUP if the FIFO still holds an entry after the pop (PSEL stays 1, PENABLE drops to 0); otherwise it SHALL go to IDLE.
REQ-024 Latency: a command accepted at edge N into an empty FIFO with the FSM in IDLE gives PSEL=1 after edge N+1 and PENABLE=1 after edge N+2; with PREADY=1 at edge N+3, rsp_valid=1 after edge N+3.
REQ-025 Timeout counter: clear on entry to ACCESS; increment on each ACCESS edge with PREADY=0.
REQ-026 When the counter equals TIMEOUT_CYC-1 and PREADY=0, the transfer SHALL complete with rsp_err=1 and rsp_rdata=0, following REQ-023.
REQ-027 PREADY=1 on the timeout edge SHALL give a normal completion (PREADY wins).
REQ-028 PWDATA SHALL be 0 during read transfers and in IDLE.
REQ-029 A push while the FIFO is non-full SHALL be accepted in the same cycle as a pop.

Reset
REQ-030 PRESETn low SHALL immediately force: state IDLE, FIFO empty, counter 0, and all outputs 0 except req_ready=1.
REQ-031 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid; PSEL and PENABLE drop asynchronously.
REQ-032 After PRESETn deasserts, the first transfer SHALL need a new accepted command.

Structure
REQ-033 Package apb_pkg SHALL hold the state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the register address constants (CR1=3'd0, CR2=3'd1, BR=3'd2, SR=3'd3, DR=3'd5).
REQ-034 The command buffer SHALL be a sub-module apb_cmd_fifo: synchronous FIFO with width 1+ADDR_W+DATA_W, depth FIFO_DEPTH, full and empty flags.
REQ-035 FSM, timeout counter and response registers SHALL reside in apb_master_bridge.

Verification
REQ-036 Write 0x5A to address 3'd5 with PREADY tied 1 -> SETUP then ACCESS with PADDR=5, PWRITE=1, PWDATA=0x5A; rsp_valid one cycle, rsp_err=0, rsp_rdata=0.
REQ-037 Read address 3'd0, slave returns PRDATA=0x04 with PREADY after 3 wait cycles -> PENABLE held 4 cycles; rsp_rdata=0x04, rsp_err=0.
REQ-038 Two commands pushed back-to-back -> PSEL stays 1 between transfers; sequence SETUP,ACCESS,SETUP,ACCESS; two rsp_valid pulses in order; req_ready=0 while the FIFO is full.
REQ-039 PREADY held 0 -> abort after exactly 16 ACCESS cycles with rsp_err=1, rsp_rdata=0; PREADY=1 on the 16th cycle -> normal completion, rsp_err=0.
REQ-040 PSLVERR=1 at completion -> rsp_err=1; PRESETn pulsed low mid-ACCESS -> PSEL=0 and PENABLE=0 immediately, no rsp_valid, FIFO empty.
